// File: rtl/video_pll_rst_seq.sv
// -----------------------------------------------------------------------------
// video_pll_rst_seq
//
// Reset and lock sequencer for the video PLL. Runs on the PLL reference clock,
// pulses the PLL reset, qualifies the asynchronous lock signal and releases the
// video-domain reset only after lock has been continuously high for
// STABLE_CYCLES. Lock loss in RUN re-pulses the PLL; a missing lock re-pulses
// it after LOCK_TIMEOUT cycles.
//
// Ports:
//   clkin        in   PLL reference clock (only clock)
//   reset        in   synchronous active-high block reset
//   lock         in   PLL lock, asynchronous to clkin
//   pll_reset    out  active-high PLL reset
//   video_rst    out  active-high reset for the video domain
//   ready        out  high exactly when video_rst is low
//   lock_lost    out  sticky flag, set on a lock drop while in RUN
//   retry_count  out  lock-timeout retries, saturating at 15
//   state        out  0=PLL_RST, 1=WAIT_LOCK, 2=STABLE, 3=RUN
// -----------------------------------------------------------------------------
module video_pll_rst_seq #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 840000,
  parameter int unsigned STABLE_CYCLES  = 8400
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       lock,
  output logic       pll_reset,
  output logic       video_rst,
  output logic       ready,
  output logic       lock_lost,
  output logic [3:0] retry_count,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  // Terminal counts: cnt starts at 0 on entry, so the last cycle is N-1.
  localparam logic [23:0] PLL_RST_LAST = 24'(PLL_RST_CYCLES - 32'd1);
  localparam logic [23:0] TIMEOUT_LAST = 24'(LOCK_TIMEOUT - 32'd1);
  localparam logic [23:0] STABLE_LAST  = 24'(STABLE_CYCLES - 32'd1);

  logic        sync_meta_q;
  logic        lock_s_q;
  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic        lock_lost_q, lock_lost_d;
  logic        pll_reset_q, pll_reset_d;
  logic        video_rst_q, video_rst_d;
  logic        ready_q, ready_d;

  // Two-flop synchronizer bringing the asynchronous lock into clkin.
  always_ff @(posedge clkin) begin
    if (reset) begin
      sync_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      sync_meta_q <= lock;
      lock_s_q    <= sync_meta_q;
    end
  end

  // Next-state, counter and sticky-status logic.
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    lock_lost_d = lock_lost_q;
    case (state_q)
      ST_PLL_RST: begin
        // lock_s is deliberately ignored while the PLL is held in reset.
        if (cnt_q == PLL_RST_LAST) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          state_d = state_q;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a timeout on the same cycle.
        if (lock_s_q) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_PLL_RST;
          if (retry_q != 4'd15) begin
            retry_d = retry_q + 4'd1;
          end else begin
            retry_d = retry_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_STABLE: begin
        // A drop here restarts the lock wait without counting a retry.
        if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (!lock_s_q) begin
          state_d     = ST_PLL_RST;
          lock_lost_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_PLL_RST;
      end
    endcase

    // Counter restarts on every transition; it may wrap harmlessly in RUN.
    if (state_d != state_q) begin
      cnt_d = 24'd0;
    end else begin
      cnt_d = cnt_q + 24'd1;
    end
  end

  // Moore output decode from the next state so outputs move with state.
  always_comb begin
    pll_reset_d = 1'b1;
    video_rst_d = 1'b1;
    case (state_d)
      ST_PLL_RST: begin
        pll_reset_d = 1'b1;
        video_rst_d = 1'b1;
      end
      ST_WAIT_LOCK, ST_STABLE: begin
        pll_reset_d = 1'b0;
        video_rst_d = 1'b1;
      end
      ST_RUN: begin
        pll_reset_d = 1'b0;
        video_rst_d = 1'b0;
      end
      default: begin
        pll_reset_d = 1'b1;
        video_rst_d = 1'b1;
      end
    endcase
    ready_d = ~video_rst_d;
  end

  // State, counter, status and registered outputs.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= 24'd0;
      retry_q     <= 4'd0;
      lock_lost_q <= 1'b0;
      pll_reset_q <= 1'b1;
      video_rst_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lock_lost_q <= lock_lost_d;
      pll_reset_q <= pll_reset_d;
      video_rst_q <= video_rst_d;
      ready_q     <= ready_d;
    end
  end

  assign pll_reset   = pll_reset_q;
  assign video_rst   = video_rst_q;
  assign ready       = ready_q;
  assign lock_lost   = lock_lost_q;
  assign retry_count = retry_q;
  assign state       = state_q;

endmodule

// File: tb/tb_video_pll_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_video_pll_rst_seq
//
// Self-checking bench for video_pll_rst_seq with PLL_RST_CYCLES=4,
// LOCK_TIMEOUT=100, STABLE_CYCLES=16. A reference model built on the recorded
// lock history and phase durations predicts every output after every edge;
// directed steps add fixed timing checks.
// -----------------------------------------------------------------------------
module tb_video_pll_rst_seq;

  localparam int PRC = 4;
  localparam int LT  = 100;
  localparam int SC  = 16;

  localparam int PH_PLL_RST = 0;
  localparam int PH_WAIT    = 1;
  localparam int PH_STABLE  = 2;
  localparam int PH_RUN     = 3;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       lock  = 1'b0;
  logic       pll_reset, video_rst, ready, lock_lost;
  logic [3:0] retry_count;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int n        = 0;
  int rst_edge = 0;
  int ph       = 0;
  int entered  = 0;
  int retries  = 0;
  bit lost     = 1'b0;
  bit lk_hist [0:16383];

  int  seg_len;
  bit  seg_lv;
  int  rnd_steps;

  video_pll_rst_seq #(
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC)
  ) dut (
    .clkin      (clkin),
    .reset      (reset),
    .lock       (lock),
    .pll_reset  (pll_reset),
    .video_rst  (video_rst),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .retry_count(retry_count),
    .state      (state)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, n - rst_edge, obs, exp);
    end
  endtask

  task automatic go(input int p);
    ph      = p;
    entered = n;
  endtask

  // Advance the model by one edge: lock synchronised value is lock sampled two
  // edges ago (zero if a reset edge lies in between); phases last a number of
  // cycles measured from the edge they were entered.
  task automatic model_edge(input bit r, input bit v);
    bit ls;
    int dur;
    lk_hist[n] = v;
    if (r) begin
      go(PH_PLL_RST);
      retries  = 0;
      lost     = 1'b0;
      rst_edge = n;
    end else begin
      ls  = (n - 2 > rst_edge) ? lk_hist[n-2] : 1'b0;
      dur = n - entered;
      case (ph)
        PH_PLL_RST: if (dur == PRC) go(PH_WAIT);
        PH_WAIT: begin
          if (ls) go(PH_STABLE);
          else if (dur == LT) begin
            go(PH_PLL_RST);
            if (retries < 15) retries++;
          end
        end
        PH_STABLE: begin
          if (!ls) go(PH_WAIT);
          else if (dur == SC) go(PH_RUN);
        end
        PH_RUN: begin
          if (!ls) begin
            lost = 1'b1;
            go(PH_PLL_RST);
          end
        end
        default: go(PH_PLL_RST);
      endcase
    end
  endtask

  task automatic step(input bit r, input bit l);
    reset = r;
    lock  = l;
    @(posedge clkin);
    n++;
    model_edge(r, l);
    #1;
    chk("m_state",     32'(state),       32'(ph));
    chk("m_pll_reset", 32'(pll_reset),   32'(ph == PH_PLL_RST));
    chk("m_video_rst", 32'(video_rst),   32'(ph != PH_RUN));
    chk("m_ready",     32'(ready),       32'(ph == PH_RUN));
    chk("m_lock_lost", 32'(lock_lost),   32'(lost));
    chk("m_retry",     32'(retry_count), 32'(retries));
  endtask

  initial begin
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // 1: lock rises at edge 10 and stays high
    step(1'b1, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, i >= 10);
      if (i == 3)  chk("t1_pll_hi_e3", 32'(pll_reset), 32'd1);
      if (i == 4)  chk("t1_pll_lo_e4", 32'(pll_reset), 32'd0);
      if (i == 11) chk("t1_wait_e11", 32'(state), 32'd1);
      if (i == 12) chk("t1_stable_e12", 32'(state), 32'd2);
      if (i == 27) chk("t1_vrst_e27", 32'(video_rst), 32'd1);
      if (i == 28) begin
        chk("t1_vrst_e28", 32'(video_rst), 32'd0);
        chk("t1_ready_e28", 32'(ready), 32'd1);
      end
    end
    chk("t1_lost", 32'(lock_lost), 32'd0);
    chk("t1_retry", 32'(retry_count), 32'd0);

    // 2: lock held low -> periodic re-pulse, saturating retry count
    step(1'b1, 1'b0);
    for (int i = 1; i <= 1680; i++) begin
      step(1'b0, 1'b0);
      if (i % 104 == 0) begin
        chk("t2_retry", 32'(retry_count), (i / 104 > 15) ? 32'd15 : 32'(i / 104));
        chk("t2_pll_hi", 32'(pll_reset), 32'd1);
      end
      if (i % 104 == 4) chk("t2_pll_lo", 32'(pll_reset), 32'd0);
    end
    chk("t2_vrst", 32'(video_rst), 32'd1);

    // 3: high 10, low 3, high -> STABLE aborts, no retry
    step(1'b1, 1'b0);
    for (int i = 1; i <= 50; i++) begin
      step(1'b0, (i >= 10 && i <= 19) || i >= 23);
      if (i == 22) chk("t3_abort_wait", 32'(state), 32'd1);
      if (i == 40) chk("t3_ready_e40", 32'(ready), 32'd0);
      if (i == 41) chk("t3_ready_e41", 32'(ready), 32'd1);
    end
    chk("t3_retry", 32'(retry_count), 32'd0);

    // 4: one-cycle lock drop in RUN (drop sampled at edge 51)
    for (int i = 51; i <= 80; i++) begin
      step(1'b0, i != 51);
      if (i == 52) chk("t4_ready_e52", 32'(ready), 32'd1);
      if (i == 53) begin
        chk("t4_vrst_e53", 32'(video_rst), 32'd1);
        chk("t4_pll_e53", 32'(pll_reset), 32'd1);
        chk("t4_lost_e53", 32'(lock_lost), 32'd1);
      end
      if (i == 56) chk("t4_pll_e56", 32'(pll_reset), 32'd1);
      if (i == 57) chk("t4_pll_e57", 32'(pll_reset), 32'd0);
      if (i == 74) chk("t4_ready_e74", 32'(ready), 32'd1);
    end
    chk("t4_lost_kept", 32'(lock_lost), 32'd1);

    // 5: one-cycle reset in RUN with lock_lost set
    step(1'b1, 1'b1);
    chk("t5_state", 32'(state), 32'd0);
    chk("t5_pll", 32'(pll_reset), 32'd1);
    chk("t5_vrst", 32'(video_rst), 32'd1);
    chk("t5_ready", 32'(ready), 32'd0);
    chk("t5_lost", 32'(lock_lost), 32'd0);
    chk("t5_retry", 32'(retry_count), 32'd0);
    for (int i = 1; i <= 30; i++) step(1'b0, 1'b1);

    // 6: lock arrives on the timeout cycle -> lock wins
    step(1'b1, 1'b0);
    for (int i = 1; i <= 110; i++) begin
      step(1'b0, i >= 102);
      if (i == 103) chk("t6_wait_e103", 32'(state), 32'd1);
      if (i == 104) begin
        chk("t6_stable_e104", 32'(state), 32'd2);
        chk("t6_retry", 32'(retry_count), 32'd0);
      end
    end
    // 6b: one cycle later -> timeout fires first
    step(1'b1, 1'b0);
    for (int i = 1; i <= 110; i++) begin
      step(1'b0, i >= 103);
      if (i == 104) begin
        chk("t6b_pllrst_e104", 32'(state), 32'd0);
        chk("t6b_retry", 32'(retry_count), 32'd1);
      end
      if (i == 109) chk("t6b_stable_e109", 32'(state), 32'd2);
    end

    // randomized lock waveforms with occasional resets
    step(1'b1, 1'b0);
    rnd_steps = 0;
    while (rnd_steps < 3000) begin
      seg_lv = ($urandom_range(3, 0) != 0);
      if (seg_lv) seg_len = int'($urandom_range(60, 5));
      else if ($urandom_range(7, 0) == 0) seg_len = int'($urandom_range(130, 90));
      else seg_len = int'($urandom_range(8, 1));
      for (int k = 0; k < seg_len; k++) begin
        step($urandom_range(299, 0) == 0, seg_lv);
        rnd_steps++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
